// File: rtl/line_window_ctrl.sv
// Streams raster pixels into NBUF line buffers and emits a KROWS x KROWS sliding window with
// valid/ready on both sides. Optional sticky overflow flag: define LINE_WINDOW_OVF_EN.
module line_window_ctrl #(
   parameter int PIX_W    = 8,
   parameter int LINE_LEN = 512,
   parameter int KROWS    = 3,
   parameter int NBUF     = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [PIX_W-1:0]             i_pixel_data,
   input  logic                         i_pixel_data_valid,
   output logic                         o_pixel_ready,
   output logic [KROWS*KROWS*PIX_W-1:0] o_pixel_data,
   output logic                         o_pixel_data_valid,
   input  logic                         i_pixel_ready,
   output logic                         o_interrupt
`ifdef LINE_WINDOW_OVF_EN
   ,
   output logic                         o_overflow
`endif
);

   localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int PTR_W = (NBUF > 1) ? $clog2(NBUF) : 1;
   localparam int CNT_W = $clog2(NBUF + 1);
   localparam int WIN_W = KROWS * KROWS * PIX_W;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
   localparam logic [COL_W-1:0] RD_LAST  = COL_W'(LINE_LEN - KROWS);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     wr_buf_q, wr_buf_d;
   logic [COL_W-1:0]     wr_col_q, wr_col_d;
   logic [CNT_W-1:0]     full_cnt_q, full_cnt_d;
   logic [PTR_W-1:0]     rd_base_q, rd_base_d;
   logic [COL_W-1:0]     rd_col_q, rd_col_d;
   logic [WIN_W-1:0]     data_q, data_d;
   logic                 vld_q, vld_d;
   logic                 irq_q, irq_d;
   logic [WIN_W-1:0]     win;
   logic                 wr_fire, line_done, load, release_row;
   logic [PIX_W-1:0]     lbuf_q [NBUF][LINE_LEN];

   function automatic logic [PTR_W-1:0] buf_add(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NBUF) s = s - NBUF;
      return PTR_W'(s);
   endfunction

   assign o_pixel_ready      = (full_cnt_q < CNT_W'(NBUF));
   assign wr_fire            = i_pixel_data_valid & o_pixel_ready;
   assign line_done          = wr_fire & (wr_col_q == COL_LAST);
   assign load               = ~vld_q | i_pixel_ready;
   assign o_pixel_data       = data_q;
   assign o_pixel_data_valid = vld_q;
   assign o_interrupt        = irq_q;

   // The write buffer is never one being read: it only becomes readable once its line completes.
   always_ff @(posedge clk) begin
      if (wr_fire) lbuf_q[wr_buf_q][wr_col_q] <= i_pixel_data;
   end

   always_comb begin
      win = '0;
      for (int r = 0; r < KROWS; r++) begin
         for (int c = 0; c < KROWS; c++) begin
            win[(r*KROWS+c)*PIX_W +: PIX_W] = lbuf_q[buf_add(rd_base_q, r)][rd_col_q + COL_W'(c)];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_col_d    = rd_col_q;
      rd_base_d   = rd_base_q;
      data_d      = data_q;
      vld_d       = vld_q;
      release_row = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (full_cnt_q >= CNT_W'(KROWS)) state_d = S_READ;
         end
         S_READ: begin
            if (load) begin
               data_d = win;
               vld_d  = 1'b1;
               if (rd_col_q == RD_LAST) begin
                  rd_col_d = '0;
                  state_d  = S_DRAIN;
               end else begin
                  rd_col_d = rd_col_q + COL_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // Only the last window of the row is outstanding here.
            if (i_pixel_ready) begin
               vld_d       = 1'b0;
               release_row = 1'b1;
               rd_base_d   = buf_add(rd_base_q, 1);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_col_d   = wr_col_q;
      wr_buf_d   = wr_buf_q;
      full_cnt_d = full_cnt_q;
      irq_d      = release_row;
      if (wr_fire) begin
         if (line_done) begin
            wr_col_d = '0;
            wr_buf_d = buf_add(wr_buf_q, 1);
         end else begin
            wr_col_d = wr_col_q + COL_W'(1);
         end
      end
      if (line_done && !release_row) full_cnt_d = full_cnt_q + CNT_W'(1);
      else if (!line_done && release_row) full_cnt_d = full_cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wr_buf_q   <= '0;
         wr_col_q   <= '0;
         full_cnt_q <= '0;
         rd_base_q  <= '0;
         rd_col_q   <= '0;
         data_q     <= '0;
         vld_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_buf_q   <= wr_buf_d;
         wr_col_q   <= wr_col_d;
         full_cnt_q <= full_cnt_d;
         rd_base_q  <= rd_base_d;
         rd_col_q   <= rd_col_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
         irq_q      <= irq_d;
      end
   end

`ifdef LINE_WINDOW_OVF_EN
   logic ovf_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else if (i_pixel_data_valid && !o_pixel_ready) ovf_q <= 1'b1;
   end
   assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: directed vector table, hand-written corner sequences and a randomized
// run scored against a line-queue reference model.
module tb_line_window_ctrl;

   localparam int L     = 8;
   localparam int K     = 3;
   localparam int NB    = 4;
   localparam int PW    = 8;
   localparam int WIN_W = K * K * PW;
   localparam int NWIN  = L - K + 1;

   typedef logic [L*PW-1:0] line_t;
   typedef struct {
      logic rdy;
      logic vld;
      logic irq;
      int   col;
   } vec_t;

   logic             clk, rst;
   logic [PW-1:0]    i_data;
   logic             i_valid, i_rdy;
   logic             o_ready, o_valid, o_irq;
   logic [WIN_W-1:0] o_data;
`ifdef LINE_WINDOW_OVF_EN
   logic             o_ovf;
`endif

   int tests = 0;
   int fails = 0;

   // reference model state
   line_t            done[$];
   line_t            cur;
   int               cur_n, exp_col, fed, irq_seen;
   logic             exp_irq;
   logic             first_seen;
   logic [WIN_W-1:0] first_win;

   line_window_ctrl #(.PIX_W(PW), .LINE_LEN(L), .KROWS(K), .NBUF(NB)) dut (
      .clk               (clk),
      .reset             (rst),
      .i_pixel_data      (i_data),
      .i_pixel_data_valid(i_valid),
      .o_pixel_ready     (o_ready),
      .o_pixel_data      (o_data),
      .o_pixel_data_valid(o_valid),
      .i_pixel_ready     (i_rdy),
      .o_interrupt       (o_irq)
`ifdef LINE_WINDOW_OVF_EN
      ,
      .o_overflow        (o_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pat(input int idx);
      return PW'((idx / L) * 16 + (idx % L));
   endfunction

   function automatic logic [WIN_W-1:0] mkwin(input int row0, input int col);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w[(r*K+c)*PW +: PW] = PW'((row0 + r) * 16 + col + c);
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] model_win();
      logic [WIN_W-1:0] w;
      line_t ln;
      w = '0;
      for (int r = 0; r < K; r++) begin
         ln = done[r];
         for (int c = 0; c < K; c++) w[(r*K+c)*PW +: PW] = ln[(exp_col + c)*PW +: PW];
      end
      return w;
   endfunction

   task automatic model_reset();
      done.delete();
      cur = '0; cur_n = 0; exp_col = 0; fed = 0; irq_seen = 0;
      exp_irq = 1'b0; first_seen = 1'b0; first_win = '0;
   endtask

   // One clock: drive at the falling edge, compare, then advance the model across the rising edge.
   task automatic cycle(input logic vin, input logic [PW-1:0] din, input logic rin);
      bit wf, rf, rel;
      i_valid = vin; i_data = din; i_rdy = rin;
      #1;
      chk("pixel_ready", WIN_W'(o_ready), WIN_W'(done.size() < NB));
      chk("interrupt", WIN_W'(o_irq), WIN_W'(exp_irq));
      if (o_irq) irq_seen++;
      if (o_valid) begin
         if (done.size() < K) chk("spurious_window", WIN_W'(o_valid), '0);
         else chk("window", o_data, model_win());
         if (!first_seen) begin
            first_seen = 1'b1;
            first_win  = o_data;
         end
      end
      wf = vin && (done.size() < NB);
      rf = o_valid && rin;
      @(posedge clk);
      rel = 1'b0;
      if (rf && done.size() >= K) begin
         exp_col++;
         if (exp_col == NWIN) begin
            void'(done.pop_front());
            exp_col = 0;
            rel = 1'b1;
         end
      end
      if (wf) begin
         cur[cur_n*PW +: PW] = din;
         cur_n++;
         fed++;
         if (cur_n == L) begin
            done.push_back(cur);
            cur_n = 0;
         end
      end
      exp_irq = rel;
      @(negedge clk);
   endtask

   task automatic run(input int ncyc, input int nlines, input int rdy_pct, input bit rnd, input int vld_pct);
      logic v, r;
      logic [PW-1:0] d;
      for (int n = 0; n < ncyc; n++) begin
         v = (fed < nlines * L) && (int'($urandom_range(99, 0)) < vld_pct);
         d = rnd ? PW'($urandom) : pat(fed);
         r = int'($urandom_range(99, 0)) < rdy_pct;
         cycle(v, d, r);
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 300; n++) begin
         if (done.size() < K && !exp_irq) break;
         cycle(1'b0, '0, 1'b1);
      end
      chk("drain_rows_left", WIN_W'(done.size() < K), WIN_W'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1; i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   vec_t tbl[15];

   initial begin
      // Windows after the edge completing line 3: two-cycle latency, 5-cycle stall on window 1.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 0};
      for (int i = 3; i <= 7; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 2};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 3};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 4};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 5};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 0};

      rst = 1'b1; i_valid = 1'b0; i_data = '0; i_rdy = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_ready", WIN_W'(o_ready), WIN_W'(1));
      chk("reset_valid", WIN_W'(o_valid), '0);
      chk("reset_irq", WIN_W'(o_irq), '0);
      chk("reset_data", o_data, '0);
`ifdef LINE_WINDOW_OVF_EN
      chk("reset_ovf", WIN_W'(o_ovf), '0);
`endif
      rst = 1'b0;

      // table-driven: stream 3 lines then walk one output row
      for (int i = 0; i < 3 * L; i++) begin
         i_valid = 1'b1; i_data = pat(i);
         @(posedge clk);
         @(negedge clk);
      end
      i_valid = 1'b0;
      for (int k = 0; k < 15; k++) begin
         i_rdy = tbl[k].rdy;
         #1;
         chk($sformatf("tbl%0d_valid", k), WIN_W'(o_valid), WIN_W'(tbl[k].vld));
         chk($sformatf("tbl%0d_irq", k), WIN_W'(o_irq), WIN_W'(tbl[k].irq));
         chk($sformatf("tbl%0d_ready", k), WIN_W'(o_ready), WIN_W'(1));
         if (tbl[k].vld) chk($sformatf("tbl%0d_win", k), o_data, mkwin(0, tbl[k].col));
         @(posedge clk);
         @(negedge clk);
      end

      // downstream stalled while 5 lines arrive: input must stop after line 4
      do_reset();
      run(60, 5, 0, 1'b0, 100);
      chk("s3_fed_before_stall", WIN_W'(fed), WIN_W'(4 * L));
      chk("s3_ready_low", WIN_W'(o_ready), '0);
      run(200, 5, 100, 1'b0, 100);
      drain();
      chk("s3_fed_total", WIN_W'(fed), WIN_W'(5 * L));
      chk("s3_irq_count", WIN_W'(irq_seen), WIN_W'(3));

      // 10 lines continuous
      do_reset();
      run(400, 10, 100, 1'b0, 100);
      drain();
      chk("s4_fed_total", WIN_W'(fed), WIN_W'(10 * L));
      chk("s4_irq_count", WIN_W'(irq_seen), WIN_W'(8));

      // reset while the second row is being read
      do_reset();
      for (int n = 0; n < 300; n++) begin
         if (irq_seen >= 1 && o_valid) break;
         cycle(fed < 4 * L, pat(fed), 1'b1);
      end
      chk("s5_row2_reached", WIN_W'(irq_seen >= 1 && o_valid), WIN_W'(1));
      rst = 1'b1;
      #1;
      chk("s5_rst_valid", WIN_W'(o_valid), '0);
      chk("s5_rst_data", o_data, '0);
      chk("s5_rst_irq", WIN_W'(o_irq), '0);
      chk("s5_rst_ready", WIN_W'(o_ready), WIN_W'(1));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run(100, 3, 100, 1'b0, 100);
      drain();
      chk("s5_first_win", first_win, mkwin(0, 0));
      chk("s5_irq_count", WIN_W'(irq_seen), WIN_W'(1));

      // randomized traffic on both sides
      do_reset();
      run(1500, 100000, 60, 1'b1, 70);
      drain();

`ifdef LINE_WINDOW_OVF_EN
      do_reset();
      chk("ovf_clear", WIN_W'(o_ovf), '0);
      run(60, 5, 0, 1'b0, 100);
      chk("ovf_set", WIN_W'(o_ovf), WIN_W'(1));
      drain();
      chk("ovf_sticky", WIN_W'(o_ovf), WIN_W'(1));
      do_reset();
      chk("ovf_reset", WIN_W'(o_ovf), '0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
